// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: qualifies a synchronised PLL lock, then releases the
// active-low domain resets one at a time, and re-asserts them together on lock loss or software request.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 1024,
  parameter int STAGE_DELAY = 256,
  parameter int HOLD_CYCLES = 64
) (
  input  logic                   CLK_IN,
  input  logic                   nRST,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] rst_n,
  output logic                   seq_done,
  output logic [2:0]             state
);

  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int SW = $clog2(STAGE_DELAY + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [FW-1:0] FLT_DONE  = FW'(LOCK_FILTER);
  localparam logic [SW-1:0] STG_LAST  = SW'(STAGE_DELAY - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_FILTER    = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [FW-1:0]          r_flt_cnt;
  logic [FW-1:0]          w_flt_nxt;
  logic [SW-1:0]          r_stg_cnt;
  logic [SW-1:0]          w_stg_nxt;
  logic [HW-1:0]          r_hold_cnt;
  logic [HW-1:0]          w_hold_nxt;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          w_idx_nxt;
  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic [NUM_DOMAINS-1:0] w_rst_nxt;
  logic                   r_done;
  logic                   w_done_nxt;

  // Lock synchroniser: the FSM only ever looks at the last stage.
  always_ff @(posedge CLK_IN or negedge nRST) begin
    if (!nRST) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Next-state, counter and output-register logic.
  always_comb begin
    w_state_nxt = r_state;
    w_flt_nxt   = r_flt_cnt;
    w_stg_nxt   = r_stg_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst_n;
    w_done_nxt  = r_done;

    case (r_state)
      S_WAIT_LOCK: begin
        w_rst_nxt  = '0;
        w_done_nxt = 1'b0;
        w_stg_nxt  = '0;
        w_hold_nxt = '0;
        w_idx_nxt  = '0;
        if (w_lock_s) begin
          w_state_nxt = S_FILTER;
          w_flt_nxt   = FW'(1);
        end else begin
          w_state_nxt = S_WAIT_LOCK;
          w_flt_nxt   = '0;
        end
      end

      S_FILTER: begin
        w_rst_nxt  = '0;
        w_done_nxt = 1'b0;
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_flt_nxt   = '0;
        end else if (r_flt_cnt == FLT_DONE) begin
          w_rst_nxt[0] = 1'b1;
          w_flt_nxt    = '0;
          w_stg_nxt    = '0;
          w_idx_nxt    = IW'(1);
          if (NUM_DOMAINS == 1) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RELEASE;
          end
        end else begin
          w_flt_nxt = r_flt_cnt + FW'(1);
        end
      end

      S_RELEASE: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_rst_nxt   = '0;
          w_done_nxt  = 1'b0;
          w_stg_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (sw_reset_req) begin
          w_state_nxt = S_HOLD;
          w_rst_nxt   = '0;
          w_done_nxt  = 1'b0;
          w_stg_nxt   = '0;
          w_idx_nxt   = '0;
          w_hold_nxt  = '0;
        end else if (r_stg_cnt == STG_LAST) begin
          w_rst_nxt[r_idx] = 1'b1;
          w_stg_nxt        = '0;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b1;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end else begin
          w_stg_nxt = r_stg_cnt + SW'(1);
        end
      end

      S_RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_rst_nxt   = '0;
          w_done_nxt  = 1'b0;
        end else if (sw_reset_req) begin
          w_state_nxt = S_HOLD;
          w_rst_nxt   = '0;
          w_done_nxt  = 1'b0;
          w_hold_nxt  = '0;
        end else begin
          w_rst_nxt  = '1;
          w_done_nxt = 1'b1;
        end
      end

      S_HOLD: begin
        w_rst_nxt  = '0;
        w_done_nxt = 1'b0;
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_hold_nxt  = '0;
          w_flt_nxt   = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          // The exit edge itself sampled lock high, so it is the first
          // qualifying cycle; release then lands LOCK_FILTER edges later.
          w_state_nxt = S_FILTER;
          w_hold_nxt  = '0;
          w_flt_nxt   = FW'(1);
        end else begin
          w_hold_nxt = r_hold_cnt + HW'(1);
        end
      end

      default: begin
        w_state_nxt = S_WAIT_LOCK;
        w_flt_nxt   = '0;
        w_stg_nxt   = '0;
        w_hold_nxt  = '0;
        w_idx_nxt   = '0;
        w_rst_nxt   = '0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK_IN or negedge nRST) begin
    if (!nRST) begin
      r_state    <= S_WAIT_LOCK;
      r_flt_cnt  <= '0;
      r_stg_cnt  <= '0;
      r_hold_cnt <= '0;
      r_idx      <= '0;
      r_rst_n    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_flt_cnt  <= w_flt_nxt;
      r_stg_cnt  <= w_stg_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_idx      <= w_idx_nxt;
      r_rst_n    <= w_rst_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign rst_n    = r_rst_n;
  assign seq_done = r_done;
  assign state    = r_state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Randomised bench for rst_seq_ctrl against a timeline model: each output
// is derived from the number of edges elapsed since lock qualification began.
module tb_rst_seq_ctrl;

  localparam int N  = 3;
  localparam int SS = 2;
  localparam int LF = 8;
  localparam int SD = 4;
  localparam int HC = 5;

  localparam int M_WAIT = 0;
  localparam int M_QUAL = 1;
  localparam int M_HOLD = 2;

  logic         CLK_IN = 1'b0;
  logic         nRST;
  logic         pll_locked;
  logic         sw_reset_req;
  logic [N-1:0] rst_n;
  logic         seq_done;
  logic [2:0]   state;

  int total = 0;
  int bad   = 0;

  int          m_mode;
  int          m_t;
  int          m_h;
  bit [SS-1:0] m_sync;

  rst_seq_ctrl #(
    .NUM_DOMAINS(N),
    .SYNC_STAGES(SS),
    .LOCK_FILTER(LF),
    .STAGE_DELAY(SD),
    .HOLD_CYCLES(HC)
  ) dut (
    .CLK_IN      (CLK_IN),
    .nRST        (nRST),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .rst_n       (rst_n),
    .seq_done    (seq_done),
    .state       (state)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic chk_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_WAIT;
    m_t    = 0;
    m_h    = 0;
    m_sync = '0;
  endtask

  // One clock edge of the model, with the raw inputs present at that edge.
  task automatic model_edge(input bit raw, input bit sw);
    bit lk;
    lk     = m_sync[SS-1];
    m_sync = {m_sync[SS-2:0], raw};
    case (m_mode)
      M_WAIT: begin
        if (lk) begin
          m_mode = M_QUAL;
          m_t    = 0;
        end
      end
      M_QUAL: begin
        if (!lk) m_mode = M_WAIT;
        else if (sw && m_t >= LF) begin
          m_mode = M_HOLD;
          m_h    = 0;
        end else if (m_t < LF + N * SD) m_t++;
      end
      default: begin
        if (!lk) m_mode = M_WAIT;
        else begin
          m_h++;
          if (m_h == HC) begin
            m_mode = M_QUAL;
            m_t    = 0;
          end
        end
      end
    endcase
  endtask

  function automatic int released();
    int r;
    if (m_mode != M_QUAL || m_t < LF) return 0;
    r = 1 + (m_t - LF) / SD;
    return (r > N) ? N : r;
  endfunction

  task automatic check_outputs(input string tag);
    int rel;
    int exp_state;
    rel = released();
    if (m_mode == M_WAIT)      exp_state = 0;
    else if (m_mode == M_HOLD) exp_state = 4;
    else if (m_t < LF)         exp_state = 1;
    else if (rel == N)         exp_state = 3;
    else                       exp_state = 2;
    chk_val({tag, "_rst_n"}, int'(rst_n), (1 << rel) - 1);
    chk_val({tag, "_done"}, int'(seq_done), (rel == N) ? 1 : 0);
    chk_val({tag, "_state"}, int'(state), exp_state);
  endtask

  task automatic step(input bit lk, input bit sw);
    pll_locked   = lk;
    sw_reset_req = sw;
    @(posedge CLK_IN);
    model_edge(lk, sw);
    #1;
    check_outputs("cyc");
  endtask

  task automatic async_reset();
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    check_outputs("arst");
    #2;
    nRST = 1'b1;
  endtask

  task automatic run_until(input int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_mode == M_QUAL && m_t == target) begin
        hit = 1'b1;
        break;
      end
      step(1'b1, 1'b0);
    end
    chk_val("reach_target", int'(hit), 1);
  endtask

  initial begin
    bit raw;
    nRST         = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge CLK_IN);
    #1;
    nRST = 1'b1;

    // Clean lock through to RUN.
    repeat (SS + LF + (N - 1) * SD + 4) step(1'b1, 1'b0);
    chk_val("s1_rst_n", int'(rst_n), 7);
    chk_val("s1_state", int'(state), 3);
    chk_val("s1_done", int'(seq_done), 1);

    // Lock drop in RUN.
    repeat (SS + 1) step(1'b0, 1'b0);
    chk_val("s3_rst_n", int'(rst_n), 0);
    chk_val("s3_state", int'(state), 0);

    // One-cycle glitch low during filtering, then full sequence.
    repeat (SS + 5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (SS + LF + (N - 1) * SD + 4) step(1'b1, 1'b0);
    chk_val("s2_state", int'(state), 3);

    // Software request in RUN.
    step(1'b1, 1'b1);
    chk_val("s4_state", int'(state), 4);
    chk_val("s4_rst_n", int'(rst_n), 0);
    repeat (HC + LF + (N - 1) * SD + 2) step(1'b1, 1'b0);
    chk_val("s4_final", int'(rst_n), 7);

    // Software request coinciding with lock loss in RELEASE.
    repeat (SS + 1) step(1'b0, 1'b0);
    run_until(LF + 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk_val("s5_state", int'(state), 0);
    step(1'b0, 1'b1);
    chk_val("s5_ignore", int'(state), 0);

    // Asynchronous reset with two domains released.
    run_until(LF + SD + 1);
    chk_val("s6_pre", int'(rst_n), 3);
    async_reset();
    chk_val("s6_rst_n", int'(rst_n), 0);
    chk_val("s6_state", int'(state), 0);
    repeat (SS + LF + (N - 1) * SD + 4) step(1'b1, 1'b0);

    // Randomised lock, software and reset activity.
    raw = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (raw && $urandom_range(0, 99) < 2) raw = 1'b0;
      else if (!raw && $urandom_range(0, 99) < 40) raw = 1'b1;
      if ($urandom_range(0, 999) < 3) async_reset();
      step(raw, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
